// File: rtl/rca_seq_pkg.sv
// rca_seq_pkg: shared state encoding and default sizing for the slice sequencer
package rca_seq_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_SLICES = 4;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
endpackage

// File: rtl/ripply_carry_adder.sv
// ripply_carry_adder: WIDTH-bit ripple-carry adder built from full-adder cells
module ripply_carry_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i] = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[WIDTH];
endmodule

// File: rtl/rca_slice_sequencer.sv
// rca_slice_sequencer: adds two N-bit operands one WIDTH-bit slice per cycle on a shared adder
module rca_slice_sequencer
  import rca_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICES = DEF_SLICES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH*SLICES-1:0] a,
  input  logic [WIDTH*SLICES-1:0] b,
  input  logic                    cin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH*SLICES-1:0] sum,
  output logic                    cout,
  output logic                    busy
);
  localparam int N = WIDTH * SLICES;
  localparam int KW = SLICES > 1 ? $clog2(SLICES) : 1;
  state_t state, nxt;
  logic [N-1:0] a_r, b_r;
  logic [KW-1:0] k;
  logic carry, last, co;
  logic [WIDTH-1:0] s;
  ripply_carry_adder #(.WIDTH(WIDTH)) u_rca (
    .a(a_r[k*WIDTH +: WIDTH]),
    .b(b_r[k*WIDTH +: WIDTH]),
    .cin(carry),
    .sum(s),
    .cout(co)
  );
  assign last = k == KW'(SLICES - 1);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (in_valid ? ADD : IDLE)
        : state == ADD ? (last ? DONE : ADD)
        : (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_r <= '0;
      b_r <= '0;
      k <= '0;
      carry <= 1'b0;
      sum <= '0;
      cout <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && in_valid) begin
        a_r <= a;
        b_r <= b;
        carry <= cin;
        k <= '0;
      end
      if (state == ADD) begin
        sum[k*WIDTH +: WIDTH] <= s;
        carry <= co;
        k <= last ? '0 : k + 1'b1;
        if (last) cout <= co;
      end
    end
  end
endmodule

// File: tb/tb_rca_slice_sequencer.sv
// tb_rca_slice_sequencer: directed checks of the slice sequencer at WIDTH=4, SLICES=4
module tb_rca_slice_sequencer;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, cin = 0, out_valid, out_ready = 0, cout, busy;
  logic [15:0] a = 0, b = 0, sum;
  int checks = 0, errors = 0;
  rca_slice_sequencer #(.WIDTH(4), .SLICES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic accept(input logic [15:0] ta, input logic [15:0] tb, input logic tc);
    a = ta; b = tb; cin = tc; in_valid = 1;
    step();
    in_valid = 0;
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
  endtask
  int n;
  int t [$];
  initial begin
    #12;
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_valid", out_valid, 0);
    rst = 0;
    step();
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    accept(16'hFFFF, 16'h0001, 0);
    chk("busy_add", busy, 1);
    wait_valid(n);
    chk("lat_ffff", n, 4);
    chk("sum_ffff", sum, 16'h0000);
    chk("cout_ffff", cout, 1);
    out_ready = 1;
    step();
    out_ready = 0;
    chk("idle_after_hs", in_ready, 1);
    accept(16'h1234, 16'h4321, 1);
    wait_valid(n);
    chk("lat_1234", n, 4);
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_sum", sum, 16'h5556);
      chk("hold_cout", cout, 0);
      chk("hold_ready", in_ready, 0);
      step();
    end
    out_ready = 1;
    chk("hs_ready_low", in_ready, 0);
    step();
    out_ready = 0;
    chk("post_hs_ready", in_ready, 1);
    chk("post_hs_valid", out_valid, 0);
    chk("retain_sum", sum, 16'h5556);
    accept(16'h00FF, 16'h0001, 0);
    a = 16'hAAAA; in_valid = 1;
    for (int i = 0; i < 2; i++) begin
      chk("ign_ready", in_ready, 0);
      step();
    end
    in_valid = 0;
    wait_valid(n);
    chk("ign_sum", sum, 16'h0100);
    chk("ign_cout", cout, 0);
    out_ready = 1;
    step();
    out_ready = 0;
    chk("ign_no_queue", busy, 0);
    accept(16'h8888, 16'h8888, 1);
    step();
    step();
    #2 rst = 1;
    #1;
    chk("abort_sum", sum, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    step();
    rst = 0;
    step();
    chk("abort_ready", in_ready, 1);
    accept(16'h0F0F, 16'h00F1, 0);
    wait_valid(n);
    chk("lat_0f0f", n, 4);
    chk("sum_0f0f", sum, 16'h1000);
    chk("cout_0f0f", cout, 0);
    a = 16'h8000; b = 16'h8000; cin = 1; in_valid = 1; out_ready = 1;
    for (int c = 0; c < 30 && t.size() < 3; c++) begin
      step();
      if (out_valid) begin
        t.push_back(c);
        chk("b2b_sum", sum, 16'h0001);
        chk("b2b_cout", cout, 1);
        chk("b2b_ready_hs", in_ready, 0);
      end
    end
    chk("b2b_count", t.size(), 3);
    if (t.size() == 3) begin
      chk("b2b_gap1", t[1] - t[0], 6);
      chk("b2b_gap2", t[2] - t[1], 6);
    end
    in_valid = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
